fetch_instr: RTL

FETCH_INSTR -- requirements
Module: fetch_instr

---
 rtl/fetch_instr.sv | 77 +++++++
 1 files changed

// File: rtl/fetch_instr.sv
// Instruction fetch stage: reads one word per request from instruction
// memory and holds it for the decoder under a valid/ready handshake.
module fetch_instr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        jump,
  input  logic [4:0]  jump_addr,
  output logic        mem_rd,
  output logic [4:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [23:0] mem_data,
  output logic [23:0] instrucao,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [4:0]  pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t     state;
  logic [4:0] redirect;

  // Target for the next fetch when a jump may be honoured
  assign redirect = jump ? jump_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= 5'd0;
      mem_rd      <= 1'b0;
      mem_addr    <= 5'd0;
      instrucao   <= 24'd0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pc <= redirect;
          if (start) begin
            state    <= FETCH;
            mem_rd   <= 1'b1;
            mem_addr <= redirect;
          end
        end
        FETCH: begin
          if (mem_ack && mem_rd) begin
            instrucao   <= mem_data;
            instr_valid <= 1'b1;
            mem_rd      <= 1'b0;
            pc          <= pc + 5'd1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready && instr_valid) begin
            instr_valid <= 1'b0;
            pc          <= redirect;
            if (halt) begin
              state <= IDLE;
            end else begin
              state    <= FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= redirect;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
